// File: rtl/ff_exc_pkg.sv
// Shared encodings for the flip-flop excitation sequencer and its excitation LUT.
package ff_exc_pkg;

    localparam logic [1:0] MODE_SR = 2'd0;
    localparam logic [1:0] MODE_JK = 2'd1;
    localparam logic [1:0] MODE_D  = 2'd2;
    localparam logic [1:0] MODE_T  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    localparam logic [1:0] EXC_HOLD = 2'b00;

    // Excitation that keeps a flip-flop of the given type in state q.
    function automatic logic [1:0] hold_exc(input logic [1:0] mode, input logic q);
        logic [1:0] v;
        if (mode == MODE_D) begin
            v = {q, 1'b0};
        end else begin
            v = EXC_HOLD;
        end
        return v;
    endfunction

endpackage

// File: rtl/ff_excitation_seq_lut.sv
// Combinational excitation table: (mode, q, q_next) -> exc; i_hold selects the hold excitation for q.
module ff_exc_lut
    import ff_exc_pkg::*;
(
    input  logic [1:0] i_mode,
    input  logic       i_q_cur,
    input  logic       i_q_next,
    input  logic       i_hold,
    output logic [1:0] o_exc
);

    // Transition lookup; S=R=1 / J=K=1 is never produced.
    always_comb begin
        o_exc = EXC_HOLD;
        if (i_hold) begin
            o_exc = hold_exc(i_mode, i_q_cur);
        end else begin
            case (i_mode)
                MODE_SR, MODE_JK: begin
                    if (i_q_cur == i_q_next) begin
                        o_exc = EXC_HOLD;
                    end else if (i_q_next) begin
                        o_exc = 2'b10;
                    end else begin
                        o_exc = 2'b01;
                    end
                end
                MODE_D:  o_exc = {i_q_next, 1'b0};
                MODE_T:  o_exc = {i_q_cur ^ i_q_next, 1'b0};
                default: o_exc = EXC_HOLD;
            endcase
        end
    end

endmodule

// File: rtl/ff_excitation_seq.sv
// Excitation sequencer: turns desired next-q values into S/R, J/K, D or T drive and checks q_fb.
// Macro FF_FB_CHECK_EN enables the SETTLE/CHECK feedback comparison; without it the flow is IDLE->DRIVE.
module ff_excitation_seq
    import ff_exc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             tgt_valid,
    input  logic             tgt_q,
    output logic             tgt_ready,
    output logic [1:0]       exc,
    input  logic             q_fb,
    output logic             q_exp,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic       r_q_nxt;
    logic       r_q_exp;
    logic [1:0] r_exc;
    logic [1:0] w_exc_move;
    logic [1:0] w_exc_hold;

    ff_exc_lut u_lut_move (
        .i_mode   (mode),
        .i_q_cur  (r_q_exp),
        .i_q_next (tgt_q),
        .i_hold   (1'b0),
        .o_exc    (w_exc_move)
    );

    // r_q_nxt equals q_exp in IDLE and is the new state during DRIVE, so it serves both hold cases.
    ff_exc_lut u_lut_hold (
        .i_mode   (r_mode),
        .i_q_cur  (r_q_nxt),
        .i_q_next (r_q_nxt),
        .i_hold   (1'b1),
        .o_exc    (w_exc_hold)
    );

    assign tgt_ready = (r_state == ST_IDLE);
    assign exc       = r_exc;
    assign q_exp     = r_q_exp;

    // Transaction FSM and excitation/expected-state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SR;
            r_q_nxt <= 1'b0;
            r_q_exp <= 1'b0;
            r_exc   <= EXC_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        r_mode  <= mode;
                        r_q_nxt <= tgt_q;
                        r_exc   <= w_exc_move;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_exc   <= w_exc_hold;
                    end
                end
                ST_DRIVE: begin
                    r_q_exp <= r_q_nxt;
                    r_exc   <= w_exc_hold;
`ifdef FF_FB_CHECK_EN
                    r_state <= ST_SETTLE;
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_SETTLE: r_state <= ST_CHECK;
                ST_CHECK:  r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FF_FB_CHECK_EN
    logic             r_chk_valid;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_err_count;
    logic             w_miss;

    assign w_miss = (q_fb != r_q_exp);

    // Feedback comparison and saturating error counter; result pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= {CNT_W{1'b0}};
        end else if (r_state == ST_CHECK) begin
            r_chk_valid <= 1'b1;
            r_mismatch  <= w_miss;
            if (w_miss && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_chk_valid <= 1'b0;
            r_mismatch  <= 1'b0;
        end
    end

    assign chk_valid = r_chk_valid;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = q_fb;
    assign chk_valid     = 1'b0;
    assign mismatch      = 1'b0;
    assign err_count     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ff_excitation_seq.sv
// Randomized bench for ff_excitation_seq with a behavioural flip-flop under test and transaction-level model.
module tb_ff_excitation_seq;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;
`ifdef FF_FB_CHECK_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             tgt_valid;
    logic             tgt_q;
    logic             tgt_ready;
    logic [1:0]       exc;
    logic             q_fb;
    logic             q_exp;
    logic             chk_valid;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    // Reference model state (transaction level)
    int m_q    = 0;
    int m_mode = 0;
    int m_err  = 0;

    // Behavioural flip-flop under test
    logic       ff_q;
    logic [1:0] ff_mode;
    logic       force_zero;

    always #5 clk = ~clk;

    ff_excitation_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .tgt_valid (tgt_valid),
        .tgt_q     (tgt_q),
        .tgt_ready (tgt_ready),
        .exc       (exc),
        .q_fb      (q_fb),
        .q_exp     (q_exp),
        .chk_valid (chk_valid),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q    <= 1'b0;
            ff_mode <= 2'd0;
        end else begin
            case (ff_mode)
                2'd0:    ff_q <= (exc == 2'b10) ? 1'b1 : (exc == 2'b01) ? 1'b0 : ff_q;
                2'd1:    ff_q <= (exc == 2'b10) ? 1'b1 : (exc == 2'b01) ? 1'b0 :
                                 (exc == 2'b11) ? ~ff_q : ff_q;
                2'd2:    ff_q <= exc[1];
                default: ff_q <= exc[1] ? ~ff_q : ff_q;
            endcase
            if (tgt_valid && tgt_ready) ff_mode <= mode;
        end
    end

    assign q_fb = force_zero ? 1'b0 : ff_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_move(input int md, input int q, input int t);
        if (md == 2) return t * 2;
        if (md == 3) return (q != t) ? 2 : 0;
        if (t == q)  return 0;
        return (t == 1) ? 2 : 1;
    endfunction

    function automatic int ref_hold(input int md, input int q);
        return (md == 2 && q == 1) ? 2 : 0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!tgt_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!tgt_ready) check_eq("ready_timeout", tgt_ready, 1);
    endtask

    task automatic run_txn(input int md, input int t, input int gap);
        int exp_mis;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            mode  = 2'($urandom);
            tgt_q = 1'($urandom);
            check_eq("idle_exc", exc, ref_hold(m_mode, m_q));
            check_eq("idle_chk", chk_valid, 0);
        end
        wait_ready();
        mode      = 2'(md);
        tgt_q     = 1'(t);
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        mode      = 2'($urandom);
        tgt_q     = 1'($urandom);
        check_eq("drive_exc", exc, ref_move(md, m_q, t));
        check_eq("drive_ready", tgt_ready, 0);
        check_eq("drive_qexp", q_exp, m_q);
        m_mode = md;
        m_q    = t;
        if (FB) begin
            @(negedge clk);
            check_eq("settle_exc", exc, ref_hold(m_mode, m_q));
            check_eq("settle_ready", tgt_ready, 0);
            check_eq("settle_qexp", q_exp, m_q);
            @(negedge clk);
            check_eq("check_ready", tgt_ready, 0);
            check_eq("check_chk", chk_valid, 0);
            exp_mis = (force_zero && t == 1) ? 1 : 0;
            if (exp_mis == 1 && m_err < SAT) m_err++;
            @(negedge clk);
            check_eq("res_chk", chk_valid, 1);
            check_eq("res_mis", mismatch, exp_mis);
            check_eq("res_err", err_count, m_err);
            check_eq("res_ready", tgt_ready, 1);
            check_eq("res_exc", exc, ref_hold(m_mode, m_q));
            check_eq("res_qexp", q_exp, m_q);
        end else begin
            @(negedge clk);
            check_eq("ret_ready", tgt_ready, 1);
            check_eq("ret_exc", exc, ref_hold(m_mode, m_q));
            check_eq("ret_qexp", q_exp, m_q);
            check_eq("ret_chk", chk_valid, 0);
            check_eq("ret_err", err_count, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        tgt_valid  = 1'b0;
        mode       = 2'd0;
        tgt_q      = 1'b0;
        force_zero = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_exc", exc, 0);
        check_eq("rst_qexp", q_exp, 0);
        check_eq("rst_chk", chk_valid, 0);
        check_eq("rst_mis", mismatch, 0);
        check_eq("rst_err", err_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", tgt_ready, 1);

        // SR from reset: 1,1,0,0
        run_txn(0, 1, 0); run_txn(0, 1, 0); run_txn(0, 0, 0); run_txn(0, 0, 0);
        // T: 1,0,0,1
        run_txn(3, 1, 0); run_txn(3, 0, 0); run_txn(3, 0, 0); run_txn(3, 1, 1);
        // D: target 1 then hold
        run_txn(2, 1, 1); run_txn(2, 1, 2);
        // JK with feedback stuck at 0: counter reaches and holds saturation
        force_zero = 1'b1;
        for (int i = 0; i < 5; i++) run_txn(1, 1, 0);
        force_zero = 1'b0;

        // Reset asserted mid-transaction (SETTLE when feedback checking is built in)
        wait_ready();
        mode      = 2'd2;
        tgt_q     = 1'b1;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", tgt_ready, 1);
        check_eq("mid_rst_exc", exc, 0);
        check_eq("mid_rst_qexp", q_exp, 0);
        check_eq("mid_rst_err", err_count, 0);
        check_eq("mid_rst_chk", chk_valid, 0);
        @(negedge clk);
        reset  = 1'b0;
        m_q    = 0;
        m_mode = 0;
        m_err  = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_chk", chk_valid, 0);
            check_eq("post_rst_exc", exc, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            force_zero = ($urandom_range(0, 5) == 0);
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
